maxpool_2x2_stream: RTL and testbench
=====================================

Name: maxpool_2x2_stream

Overview:
Streaming 2x2, stride-2 max-pooling engine for Layer_1. It sits between the convolution output stream and the next layer's input.
- Consumes a raster-ordered pixel stream, one pixel per cycle at most.
- Tracks column parity and row parity internally.
- Keeps a half-width line buffer of partial maxima.
- Emits one pooled pixel per completed 2x2 window.

Parameters:
DATA_WIDTH, 16, pixel width; values are two's-complement signed
IMG_WIDTH, 28, input columns per row (>=2)
IMG_HEIGHT, 28, input rows per frame (>=2)
CNT_WIDTH, 14, width of the internal row/column counters; must hold IMG_WIDTH-1 and IMG_HEIGHT-1

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-low reset
Clr  input  1  synchronous frame restart, active-high
In_Valid  input  1  In_Data is a valid pixel this cycle
In_Data  input  DATA_WIDTH  input pixel, signed
Out_Valid  output  1  single-cycle pulse; Out_Data holds a pooled pixel
Out_Data  output  DATA_WIDTH  pooled pixel, signed
Frame_Done  output  1  single-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (Rst=0, asynchronous):
  - col, row, hold register H, Out_Data, Out_Valid and Frame_Done all go to 0.
  - Line buffer contents are don't-care.
- Accept rule: a pixel is accepted on a rising Clk edge with In_Valid=1 and Clr=0. With In_Valid=0, all state holds; bubbles are allowed anywhere.
- Counters on accept:
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - row wraps to 0 after IMG_HEIGHT-1.
- Datapath per accepted pixel (max is signed; on equal values either operand may be selected):
  - row even, col even: H <= In_Data.
  - row even, col odd: LB[col>>1] <= max(H, In_Data).
  - row odd, col even: H <= max(LB[col>>1], In_Data).
  - row odd, col odd: Out_Data <= max(H, In_Data); Out_Valid=1 for exactly the next cycle.
- Latency: Out_Valid rises on the edge that accepts the 4th pixel of a window, i.e. visible 1 cycle after that pixel is presented.
- Out_Data holds its last value between pulses.
- Frame_Done: pulses 1 cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted; the counters are already 0. When that pixel closes a window, Frame_Done coincides with Out_Valid.
- Odd dimensions:
  - Trailing column or row pixels are consumed but never produce output (floor pooling).
  - An odd trailing column writes only H.
  - An odd trailing row writes LB and is discarded.
- Clr=1:
  - col, row and H go to 0; Out_Valid and Frame_Done go to 0 next cycle.
  - The pixel presented in that cycle is dropped.
  - LB is not cleared; every even row overwrites it before it is read.
- Reset or Clr mid-frame: partial windows are discarded; the next accepted pixel is treated as (0,0).
- Output count per full frame: floor(IMG_WIDTH/2) * floor(IMG_HEIGHT/2).

Decomposition:
- Shared Layer_1 package:
  - DATA_WIDTH default.
  - CNT_WIDTH default.
  - Signed max function used by all pooling blocks.
- One sub-module, maxpool_line_buffer:
  - IMG_WIDTH/2 entries of DATA_WIDTH.
  - One synchronous write port and one combinational read port addressed by col>>1.
  - No reset on contents.
- Counters, parity decode and output registers stay in the top module.

Test Plan:
- 4x4 frame, values 0..15 in raster order, In_Valid held high → Out_Data 5, 7, 13, 15 on four Out_Valid pulses (after pixels 5, 7, 13, 15); Frame_Done pulse together with the 15 output.
- 4x4 all-negative frame (-16..-1) → outputs -11, -9, -3, -1; checks the signed compare.
- Same 4x4 frame with In_Valid deasserted on random cycles (about 50% duty) → identical output sequence, with each output 1 cycle after its 4th pixel.
- 5x4 frame, values 0..19 → outputs 6, 8, 16, 18 only; column 4 is ignored; Frame_Done after pixel 19.
- Clr asserted after 6 pixels of a 4x4 frame, then a fresh 0..15 frame → no output from the aborted pixels; then 5, 7, 13, 15.
- Rst low for 2 cycles mid-frame → all outputs 0 immediately; a subsequent 0..15 frame yields 5, 7, 13, 15.
- Two back-to-back 4x4 frames with no gap → 8 outputs and 2 Frame_Done pulses; the second frame is unaffected by stale LB contents.

Source files
------------

// File: rtl/maxpool_2x2_stream_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_2x2_stream_pkg : shared Layer_1 pooling types, defaults, signed max
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package maxpool_2x2_stream_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 14;
  localparam int MAX_PIX_WIDTH  = 64;

  typedef logic signed [MAX_PIX_WIDTH-1:0] wide_pix_t;

  // Position inside the 2x2 window, encoded as {row[0], col[0]}
  typedef enum logic [1:0] {
    POS_TL = 2'b00,
    POS_TR = 2'b01,
    POS_BL = 2'b10,
    POS_BR = 2'b11
  } win_pos_t;

  // Callers sign-extend into wide_pix_t and size-cast the result back
  function automatic wide_pix_t smax(input wide_pix_t a, input wide_pix_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool_2x2_stream_if.sv
// ---------------------------------------------------------------------------
// maxpool_2x2_stream_if : pixel-in / pooled-pixel-out stream bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface maxpool_2x2_stream_if #(
  parameter int DATA_WIDTH = 16
);

  logic                         In_Valid;
  logic signed [DATA_WIDTH-1:0] In_Data;
  logic                         Out_Valid;
  logic signed [DATA_WIDTH-1:0] Out_Data;
  logic                         Frame_Done;

  modport master (
    output In_Valid,
    output In_Data,
    input  Out_Valid,
    input  Out_Data,
    input  Frame_Done
  );

  modport slave (
    input  In_Valid,
    input  In_Data,
    output Out_Valid,
    output Out_Data,
    output Frame_Done
  );

endinterface

`default_nettype wire

// File: rtl/maxpool_2x2_stream_line_buffer.sv
// ---------------------------------------------------------------------------
// maxpool_line_buffer : half-width buffer of top-row partial maxima
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module maxpool_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 14,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic                         Clk,
  input  wire logic                         we,
  input  wire logic        [ADDR_WIDTH-1:0] addr,
  input  wire logic signed [DATA_WIDTH-1:0] wdata,
  output logic signed      [DATA_WIDTH-1:0] rdata
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // A trailing odd column can address one past the end; its read is never used
  assign rdata = (int'(addr) < DEPTH) ? mem[addr] : '0;

endmodule

`default_nettype wire

// File: rtl/maxpool_2x2_stream.sv
// ---------------------------------------------------------------------------
// maxpool_2x2_stream : streaming 2x2 stride-2 signed max-pooling, raster input
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input wire logic Clk,
  input wire logic Rst,
  input wire logic Clr,
  maxpool_2x2_stream_if.slave stream
);

  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [CNT_WIDTH-1:0]         col;
  logic [CNT_WIDTH-1:0]         row;
  logic signed [DATA_WIDTH-1:0] hold;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         frame_done;

  logic                         accept;
  logic                         col_last;
  logic                         row_last;
  logic                         lb_we;
  logic [LB_AW-1:0]             lb_addr;
  logic signed [DATA_WIDTH-1:0] lb_rdata;
  logic signed [DATA_WIDTH-1:0] max_h;
  logic signed [DATA_WIDTH-1:0] max_lb;
  win_pos_t                     pos;

  assign accept   = stream.In_Valid & ~Clr;
  assign col_last = (col == CNT_WIDTH'(IMG_WIDTH - 1));
  assign row_last = (row == CNT_WIDTH'(IMG_HEIGHT - 1));
  assign pos      = win_pos_t'({row[0], col[0]});
  assign lb_addr  = col[LB_AW:1];
  assign lb_we    = accept & (pos == POS_TR);

  assign max_h  = DATA_WIDTH'(smax(wide_pix_t'(hold), wide_pix_t'(stream.In_Data)));
  assign max_lb = DATA_WIDTH'(smax(wide_pix_t'(lb_rdata), wide_pix_t'(stream.In_Data)));

  maxpool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (LB_DEPTH),
    .ADDR_WIDTH (LB_AW)
  ) u_line_buffer (
    .Clk   (Clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (max_h),
    .rdata (lb_rdata)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (Clr) begin
        col  <= '0;
        row  <= '0;
        hold <= '0;
      end else if (stream.In_Valid) begin
        // POS_TR only writes the line buffer, handled through lb_we
        case (pos)
          POS_TL:  hold <= stream.In_Data;
          POS_BL:  hold <= max_lb;
          POS_BR: begin
            out_data  <= max_h;
            out_valid <= 1'b1;
          end
          default: ;
        endcase

        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + CNT_WIDTH'(1);
        end else begin
          col <= col + CNT_WIDTH'(1);
        end
        frame_done <= col_last & row_last;
      end
    end
  end

  assign stream.Out_Valid  = out_valid;
  assign stream.Out_Data   = out_data;
  assign stream.Frame_Done = frame_done;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_2x2_stream.sv
// ---------------------------------------------------------------------------
// tb_maxpool_2x2_stream : randomized bench against a frame-array pooling model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_maxpool_2x2_stream;

  logic Clk = 1'b0;
  logic Rst;
  logic Clr;

  always #5 Clk = ~Clk;

  maxpool_2x2_stream_if #(.DATA_WIDTH(16)) if4 ();
  maxpool_2x2_stream_if #(.DATA_WIDTH(16)) if5 ();

  maxpool_2x2_stream #(
    .DATA_WIDTH (16),
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4),
    .CNT_WIDTH  (14)
  ) dut4 (
    .Clk    (Clk),
    .Rst    (Rst),
    .Clr    (Clr),
    .stream (if4)
  );

  maxpool_2x2_stream #(
    .DATA_WIDTH (16),
    .IMG_WIDTH  (5),
    .IMG_HEIGHT (4),
    .CNT_WIDTH  (14)
  ) dut5 (
    .Clk    (Clk),
    .Rst    (Rst),
    .Clr    (Clr),
    .stream (if5)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: whole frame kept as an array, windows pooled from it
  int sel;
  int mw, mh, mp;
  int frame [0:63];
  bit exp_valid, exp_done;
  int exp_data;
  int nout, ndone;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    mp        = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_data  = 0;
  endtask

  task automatic step(input bit v, input int d, input bit c);
    logic signed [15:0] d16;
    logic               ov, fd;
    logic signed [15:0] od;
    int r, cc, dv;
    d16 = 16'(d);
    dv  = int'(d16);
    if (sel == 0) begin
      if4.In_Valid = v;
      if4.In_Data  = d16;
      if5.In_Valid = 1'b0;
    end else begin
      if5.In_Valid = v;
      if5.In_Data  = d16;
      if4.In_Valid = 1'b0;
    end
    Clr = c;
    @(posedge Clk);
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (c) begin
      mp = 0;
    end else if (v) begin
      r  = mp / mw;
      cc = mp % mw;
      frame[mp] = dv;
      if ((r % 2 == 1) && (cc % 2 == 1)) begin
        exp_valid = 1'b1;
        exp_data  = imax(imax(frame[mp-mw-1], frame[mp-mw]),
                         imax(frame[mp-1], frame[mp]));
      end
      if (mp == mw * mh - 1) begin
        exp_done = 1'b1;
        mp = 0;
      end else begin
        mp++;
      end
    end
    #1;
    if (sel == 0) begin
      ov = if4.Out_Valid; od = if4.Out_Data; fd = if4.Frame_Done;
    end else begin
      ov = if5.Out_Valid; od = if5.Out_Data; fd = if5.Frame_Done;
    end
    chk("out_valid", ov, exp_valid);
    chk("out_data", od, exp_data);
    chk("frame_done", fd, exp_done);
    if (ov === 1'b1) nout++;
    if (fd === 1'b1) ndone++;
    Clr = 1'b0;
  endtask

  task automatic frame_seq(input int base, input bit bubbles);
    for (int p = 0; p < mw * mh; p++) begin
      if (bubbles) begin
        for (int b = 0; b < 3 && $urandom_range(1, 0) == 0; b++) step(1'b0, 0, 1'b0);
      end
      step(1'b1, base + p, 1'b0);
    end
  endtask

  task automatic rand_frame(input bit bubbles);
    logic signed [15:0] t;
    for (int p = 0; p < mw * mh; p++) begin
      if (bubbles && $urandom_range(1, 0) == 0) step(1'b0, 0, 1'b0);
      t = 16'($urandom);
      step(1'b1, int'(t), 1'b0);
    end
  endtask

  task automatic do_reset(input int n);
    if4.In_Valid = 1'b0;
    if5.In_Valid = 1'b0;
    Rst = 1'b0;
    #1;
    chk("rst_out_valid", sel == 0 ? if4.Out_Valid : if5.Out_Valid, 0);
    chk("rst_out_data", sel == 0 ? if4.Out_Data : if5.Out_Data, 0);
    chk("rst_frame_done", sel == 0 ? if4.Frame_Done : if5.Frame_Done, 0);
    repeat (n) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic signed [15:0] t;
    Rst = 1'b0;
    Clr = 1'b0;
    if4.In_Valid = 1'b0; if4.In_Data = '0;
    if5.In_Valid = 1'b0; if5.In_Data = '0;
    sel = 0; mw = 4; mh = 4;
    nout = 0; ndone = 0;
    model_reset();
    #12;
    chk("reset_out_valid", if4.Out_Valid, 0);
    chk("reset_out_data", if4.Out_Data, 0);
    chk("reset_frame_done", if4.Frame_Done, 0);
    @(negedge Clk);
    Rst = 1'b1;

    // Ramp 0..15, then idle cycles to see Out_Data hold
    nout = 0; ndone = 0;
    frame_seq(0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("n_out_ramp", nout, 4);
    chk("n_done_ramp", ndone, 1);

    nout = 0;
    frame_seq(-16, 1'b0);
    chk("n_out_neg", nout, 4);

    nout = 0;
    frame_seq(0, 1'b1);
    chk("n_out_bubbles", nout, 4);

    // Clr after 6 pixels; the Clr-cycle pixel is dropped
    for (int p = 0; p < 6; p++) step(1'b1, 100 + p, 1'b0);
    step(1'b1, 999, 1'b1);
    nout = 0;
    frame_seq(0, 1'b0);
    chk("n_out_after_clr", nout, 4);

    for (int p = 0; p < 7; p++) step(1'b1, 200 + p, 1'b0);
    do_reset(2);
    nout = 0;
    frame_seq(0, 1'b0);
    chk("n_out_after_rst", nout, 4);

    nout = 0; ndone = 0;
    rand_frame(1'b0);
    rand_frame(1'b0);
    chk("n_out_b2b", nout, 8);
    chk("n_done_b2b", ndone, 2);

    // Mixed random traffic with occasional Clr
    for (int i = 0; i < 400; i++) begin
      t = 16'($urandom);
      step($urandom_range(3, 0) != 0, int'(t), $urandom_range(31, 0) == 0);
    end

    do_reset(1);
    sel = 1; mw = 5; mh = 4;
    nout = 0; ndone = 0;
    frame_seq(0, 1'b0);
    chk("n_out_5x4", nout, 4);
    chk("n_done_5x4", ndone, 1);
    for (int f = 0; f < 3; f++) rand_frame(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
